// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core pipeline: word/register widths,
// MEM/WB bundle field widths and the MEM stage FSM encoding.
package risc_pkg;

   localparam int WORD_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 4;

   // MEM/WB bundle field widths
   localparam int MEMWB_ADD_W  = WORD_W;
   localparam int MEMWB_DATA_W = WORD_W;
   localparam int MEMWB_DEST_W = REG_ADDR_W;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } memStateT;

endpackage

// File: rtl/dmem_ram.sv
// Local data RAM: 2^ADDR_W words, combinational read, synchronous write.
// Contents are intentionally not reset.
module dmem_ram
   import risc_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [WORD_W-1:0]   wdata,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [WORD_W-1:0]   rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_W];

   // asynchronous read port
   assign rdata = mem[raddr];

   // synchronous write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined core. Loads/stores occupy the stage for
// WAIT_CYCLES+1 cycles while upstream is stalled; the MEM/WB register gets
// a bubble on every stall cycle and the real bundle on the completing edge.
//
// state | meaning
// IDLE  | ready; non-memory ops (or zero-wait accesses) pass through in one cycle
// WAIT  | access in flight; cnt counts remaining stall cycles, commit at cnt==0
module mem_access_stage
   import risc_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    res,
   input  logic                    iValid,
   input  logic [WORD_W-1:0]       iAluRes,
   input  logic [WORD_W-1:0]       iStoreData,
   input  logic [REG_ADDR_W-1:0]   iRegDest,
   input  logic                    iMemRead,
   input  logic                    iMemWrite,
   input  logic                    iRegWrite,
   input  logic                    iMemtoReg,
   output logic                    oStall,
   output logic                    oValid,
   output logic [MEMWB_ADD_W-1:0]  oMemAdd,
   output logic [MEMWB_DATA_W-1:0] oMemData,
   output logic [MEMWB_DEST_W-1:0] oRegDest,
   output logic                    oRegWrite,
   output logic                    oMemtoReg,
   output logic                    oMisalign
);

   localparam logic [CNT_W-1:0] WAIT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   memStateT          state, nextState;
   logic [CNT_W-1:0]  cnt, nextCnt;
   logic              memOp;
   logic              misalign;
   logic              capture;
   logic              complete;
   logic              ramWe;
   logic [WORD_W-1:0] ramRdata;
   logic [WORD_W-1:0] loadData;
   logic [ADDR_W-1:0] ramIdx;

   assign memOp    = iValid & (iMemRead | iMemWrite);
   assign misalign = (iAluRes[1:0] != 2'b00);
   assign ramIdx   = iAluRes[ADDR_W+1:2];

   // Store wins when both read and write are flagged; reset at the
   // completing edge aborts the commit.
   assign ramWe    = complete & iMemWrite & ~misalign & ~res;
   assign loadData = (complete & iMemRead & ~iMemWrite & ~misalign) ? ramRdata : '0;

   dmem_ram #(.ADDR_W(ADDR_W)) uRam (
      .clk   (clk),
      .we    (ramWe),
      .waddr (ramIdx),
      .wdata (iStoreData),
      .raddr (ramIdx),
      .rdata (ramRdata)
   );

   // state register and wait counter
   always_ff @(posedge clk) begin
      if (res) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   // next-state, stall and capture decode
   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      oStall    = 1'b0;
      capture   = 1'b0;
      complete  = 1'b0;
      unique case (state)
         IDLE: begin
            if (memOp) begin
               if (WAIT_CYCLES == 0) begin
                  complete = 1'b1;
                  capture  = 1'b1;
               end else begin
                  oStall    = 1'b1;
                  nextState = WAIT;
                  nextCnt   = WAIT_INIT;
               end
            end else begin
               capture = iValid;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               oStall  = 1'b1;
               nextCnt = cnt - 1'b1;
            end else begin
               complete  = 1'b1;
               capture   = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
      // reset wins over any stall request so upstream is never held in reset
      if (res) oStall = 1'b0;
   end

   // MEM/WB output register: live bundle on capture, bubble otherwise
   always_ff @(posedge clk) begin
      if (res || !capture) begin
         oValid    <= 1'b0;
         oMemAdd   <= '0;
         oMemData  <= '0;
         oRegDest  <= '0;
         oRegWrite <= 1'b0;
         oMemtoReg <= 1'b0;
         oMisalign <= 1'b0;
      end else begin
         oValid    <= iValid;
         oMemAdd   <= iAluRes;
         oMemData  <= loadData;
         oRegDest  <= iRegDest;
         oRegWrite <= iRegWrite & iValid & ~(complete & misalign);
         oMemtoReg <= iMemtoReg;
         oMisalign <= complete & misalign;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with WAIT_CYCLES=2, ADDR_W=8.
module tb_mem_access_stage;
   import risc_pkg::*;

   logic        clk = 1'b0;
   logic        res;
   logic        iValid;
   logic [31:0] iAluRes;
   logic [31:0] iStoreData;
   logic [4:0]  iRegDest;
   logic        iMemRead;
   logic        iMemWrite;
   logic        iRegWrite;
   logic        iMemtoReg;
   logic        oStall;
   logic        oValid;
   logic [31:0] oMemAdd;
   logic [31:0] oMemData;
   logic [4:0]  oRegDest;
   logic        oRegWrite;
   logic        oMemtoReg;
   logic        oMisalign;

   int nTests = 0;
   int nFail  = 0;
   int stalls;

   mem_access_stage #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
      .clk        (clk),
      .res        (res),
      .iValid     (iValid),
      .iAluRes    (iAluRes),
      .iStoreData (iStoreData),
      .iRegDest   (iRegDest),
      .iMemRead   (iMemRead),
      .iMemWrite  (iMemWrite),
      .iRegWrite  (iRegWrite),
      .iMemtoReg  (iMemtoReg),
      .oStall     (oStall),
      .oValid     (oValid),
      .oMemAdd    (oMemAdd),
      .oMemData   (oMemData),
      .oRegDest   (oRegDest),
      .oRegWrite  (oRegWrite),
      .oMemtoReg  (oMemtoReg),
      .oMisalign  (oMisalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setIn(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input logic mr, input logic mw,
                        input logic rw, input logic m2r);
      iValid = v; iAluRes = alu; iStoreData = sd; iRegDest = rd;
      iMemRead = mr; iMemWrite = mw; iRegWrite = rw; iMemtoReg = m2r;
   endtask

   task automatic idleIn();
      setIn(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Present one instruction, hold it through the stall, return the number
   // of stall cycles; on return the outputs show the instruction's result.
   task automatic runInstr(input string tag, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rd, input logic mr, input logic mw,
                           input logic rw, input logic m2r, output int nStall);
      setIn(1'b1, alu, sd, rd, mr, mw, rw, m2r);
      nStall = 0;
      #1;
      while (oStall && nStall < 20) begin
         tick();
         nStall++;
         chk({tag, "_bubbleValid"}, {31'b0, oValid}, 32'd0);
      end
      if (nStall >= 20) chk({tag, "_stallTimeout"}, 32'(nStall), 32'd2);
      tick();
      idleIn();
   endtask

   initial begin
      res = 1'b1;
      // 1: reset with a store driven for two cycles
      setIn(1'b1, 32'h40, 32'h99999999, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("rstStall", {31'b0, oStall}, 32'd0);
      tick();
      chk("rstStall2", {31'b0, oStall}, 32'd0);
      chk("rstValid", {31'b0, oValid}, 32'd0);
      chk("rstMemAdd", oMemAdd, 32'd0);
      chk("rstMemData", oMemData, 32'd0);
      chk("rstRegWrite", {31'b0, oRegWrite}, 32'd0);
      chk("rstMisalign", {31'b0, oMisalign}, 32'd0);
      idleIn();
      res = 1'b0;
      tick();

      // 1b: reset must suppress a RAM write
      runInstr("swCafe", 32'h44, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stalls);
      res = 1'b1;
      setIn(1'b1, 32'h44, 32'h12345678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      res = 1'b0;
      idleIn();
      tick();
      runInstr("lwCafe", 32'h44, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      chk("rstNoWrite", oMemData, 32'hCAFEF00D);

      // 2: ALU op passes straight through
      runInstr("alu", 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, stalls);
      chk("aluStalls", 32'(stalls), 32'd0);
      chk("aluValid", {31'b0, oValid}, 32'd1);
      chk("aluMemAdd", oMemAdd, 32'h1234);
      chk("aluRegDest", {27'b0, oRegDest}, 32'd5);
      chk("aluMemData", oMemData, 32'd0);
      chk("aluRegWrite", {31'b0, oRegWrite}, 32'd1);
      tick();
      chk("bubbleAfterAlu", {31'b0, oValid}, 32'd0);

      // 3: store then load
      runInstr("sw40", 32'h40, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stalls);
      chk("swStalls", 32'(stalls), 32'd2);
      chk("swValid", {31'b0, oValid}, 32'd1);
      chk("swMemData", oMemData, 32'd0);
      runInstr("lw40", 32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      chk("lwStalls", 32'(stalls), 32'd2);
      chk("lwMemData", oMemData, 32'hDEADBEEF);
      chk("lwMemtoReg", {31'b0, oMemtoReg}, 32'd1);
      chk("lwRegWrite", {31'b0, oRegWrite}, 32'd1);
      chk("lwRegDest", {27'b0, oRegDest}, 32'd7);

      // both read and write: store semantics, no load data
      runInstr("rwBoth", 32'h48, 32'h5555AAAA, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, stalls);
      chk("rwBothData", oMemData, 32'd0);
      runInstr("lw48", 32'h48, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      chk("rwBothStored", oMemData, 32'h5555AAAA);

      // 4: address wrap
      runInstr("sw400", 32'h400, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stalls);
      runInstr("lw000", 32'h000, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      chk("wrapData", oMemData, 32'hA5A5A5A5);

      // 5: misaligned load and store
      runInstr("lw42", 32'h42, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      chk("misStalls", 32'(stalls), 32'd2);
      chk("misFlag", {31'b0, oMisalign}, 32'd1);
      chk("misRegWrite", {31'b0, oRegWrite}, 32'd0);
      chk("misMemData", oMemData, 32'd0);
      tick();
      chk("misOneCycle", {31'b0, oMisalign}, 32'd0);
      runInstr("sw41", 32'h41, 32'h77777777, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stalls);
      chk("misSwFlag", {31'b0, oMisalign}, 32'd1);
      runInstr("lw40b", 32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      chk("misSwNoWrite", oMemData, 32'hDEADBEEF);

      // 6: reset in the second stall cycle aborts the store
      runInstr("sw80old", 32'h80, 32'h22222222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stalls);
      setIn(1'b1, 32'h80, 32'h00000011, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("midWaitStall", {31'b0, oStall}, 32'd1);
      res = 1'b1;
      tick();
      res = 1'b0;
      idleIn();
      #1;
      chk("abortStall", {31'b0, oStall}, 32'd0);
      chk("abortValid", {31'b0, oValid}, 32'd0);
      tick();
      chk("abortNoIssue", {31'b0, oValid}, 32'd0);
      runInstr("lw80", 32'h80, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      chk("abortOldValue", oMemData, 32'h22222222);

      // 6b: reset on the completing edge also suppresses the write
      runInstr("sw84old", 32'h84, 32'h33333333, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stalls);
      setIn(1'b1, 32'h84, 32'h44444444, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      res = 1'b1;
      tick();
      res = 1'b0;
      idleIn();
      tick();
      chk("abortLateValid", {31'b0, oValid}, 32'd0);
      runInstr("lw84", 32'h84, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      chk("abortLateOld", oMemData, 32'h33333333);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL globalTimeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
